// File: rtl/branch_predictor_pkg.sv
// Shared predictor constants: counter encodings and default geometry.
// Imported by the BTB top and its counter next-state helper.
package branch_predictor_pkg;

  localparam int BP_INDEX_BITS = 6;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] STK = 2'b11;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating counter next-state function.
// Ports: ctr (current), taken (outcome) -> nxt (saturated next value).
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = ctr;
    unique case (1'b1)
      taken && (ctr != STK):  nxt = ctr + 2'd1;
      !taken && (ctr != SNT): nxt = ctr - 2'd1;
      default:                nxt = ctr;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage BTB predictor: direct-mapped, 2-bit counter per entry.
// Ports: clk/rst, fetch lookup, execute update, mispredict/redirect.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter  int VAR_WIDTH  = 32,
  parameter  int INDEX_BITS = BP_INDEX_BITS,
  localparam int TAG_BITS   = VAR_WIDTH - INDEX_BITS - 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [VAR_WIDTH-1:0] fetch_pc,
  output logic                 predict_taken,
  output logic [VAR_WIDTH-1:0] predict_target,
  input  logic                 update_valid,
  input  logic [VAR_WIDTH-1:0] update_pc,
  input  logic                 update_taken,
  input  logic [VAR_WIDTH-1:0] update_target,
  input  logic                 update_pred_taken,
  input  logic [VAR_WIDTH-1:0] update_pred_target,
  output logic                 mispredict,
  output logic [VAR_WIDTH-1:0] redirect_pc
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic                 valid_q  [ENTRIES];
  logic [TAG_BITS-1:0]  tag_q    [ENTRIES];
  logic [VAR_WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]           ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0] f_idx, u_idx;
  logic [TAG_BITS-1:0]   f_tag, u_tag;
  logic                  f_hit, u_hit;
  logic [1:0]            ctr_nxt;
  logic                  unused_lo;

  assign unused_lo = ^{fetch_pc[1:0], update_pc[1:0]};

  assign f_idx = fetch_pc[INDEX_BITS+1:2];
  assign f_tag = fetch_pc[VAR_WIDTH-1:INDEX_BITS+2];
  assign u_idx = update_pc[INDEX_BITS+1:2];
  assign u_tag = update_pc[VAR_WIDTH-1:INDEX_BITS+2];

  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  assign predict_taken  = f_hit && ctr_q[f_idx][1];
  assign predict_target = predict_taken ? target_q[f_idx]
                        : fetch_pc + VAR_WIDTH'(4);

  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = '0;
    if (update_valid) begin
      mispredict = (update_taken != update_pred_taken)
                || (update_taken && update_pred_taken
                    && (update_target != update_pred_target));
      redirect_pc = update_taken ? update_target
                  : update_pc + VAR_WIDTH'(4);
    end
  end

  sat_counter2 u_ctr (
    .ctr   (ctr_q[u_idx]),
    .taken (update_taken),
    .nxt   (ctr_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= WNT;
      end
    end else if (update_valid) begin
      if (u_hit) begin
        ctr_q[u_idx] <= ctr_nxt;
        if (update_taken) target_q[u_idx] <= update_target;
      end else if (update_taken) begin
        // allocate on taken miss, evicting any alias
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= update_target;
        ctr_q[u_idx]    <= WT;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed table-driven bench for branch_predictor.
// Checks lookup, training, aliasing, reset priority and mispredict.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_pred_taken;
  logic [31:0] update_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk                (clk),
    .rst                (rst),
    .fetch_pc           (fetch_pc),
    .predict_taken      (predict_taken),
    .predict_target     (predict_target),
    .update_valid       (update_valid),
    .update_pc          (update_pc),
    .update_taken       (update_taken),
    .update_target      (update_target),
    .update_pred_taken  (update_pred_taken),
    .update_pred_target (update_pred_target),
    .mispredict         (mispredict),
    .redirect_pc        (redirect_pc)
  );

  typedef struct {
    logic        rst;
    logic [31:0] fpc;
    logic        uv;
    logic [31:0] upc;
    logic        utk;
    logic [31:0] utgt;
    logic        upt;
    logic [31:0] uptgt;
    logic        e_ptk;
    logic [31:0] e_ptgt;
    logic        e_mis;
    logic [31:0] e_red;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic r, logic [31:0] fpc,
    logic uv, logic [31:0] upc, logic utk, logic [31:0] utgt,
    logic upt, logic [31:0] uptgt,
    logic eptk, logic [31:0] eptgt, logic emis, logic [31:0] ered);
    vec_t v;
    v.rst = r; v.fpc = fpc;
    v.uv = uv; v.upc = upc; v.utk = utk; v.utgt = utgt;
    v.upt = upt; v.uptgt = uptgt;
    v.e_ptk = eptk; v.e_ptgt = eptgt;
    v.e_mis = emis; v.e_red = ered;
    return v;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // drive after negedge, check before the next posedge commits
  task automatic apply(string nm, vec_t v);
    @(negedge clk);
    rst                = v.rst;
    fetch_pc           = v.fpc;
    update_valid       = v.uv;
    update_pc          = v.upc;
    update_taken       = v.utk;
    update_target      = v.utgt;
    update_pred_taken  = v.upt;
    update_pred_target = v.uptgt;
    #1;
    check({nm, ".ptk"},  {31'd0, predict_taken}, {31'd0, v.e_ptk});
    check({nm, ".ptgt"}, predict_target, v.e_ptgt);
    check({nm, ".mis"},  {31'd0, mispredict}, {31'd0, v.e_mis});
    check({nm, ".red"},  redirect_pc, v.e_red);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; update_valid = 1'b0; fetch_pc = '0;
    update_pc = '0; update_taken = 1'b0; update_target = '0;
    update_pred_taken = 1'b0; update_pred_target = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // reset state
    tbl.push_back(mk(0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 32'h104, 0, 0));
    // allocate 0x100 -> 0x80; same-cycle lookup sees old contents
    tbl.push_back(mk(0, 32'h100, 1, 32'h100, 1, 32'h80, 0, 0,
                     0, 32'h104, 1, 32'h80));
    // counter 10 -> 11
    tbl.push_back(mk(0, 32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h80,
                     1, 32'h80, 0, 32'h80));
    // counter 11 -> 11
    tbl.push_back(mk(0, 32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h80,
                     1, 32'h80, 0, 32'h80));
    // not taken: 11 -> 10, redirect to pc+4
    tbl.push_back(mk(0, 32'h100, 1, 32'h100, 0, 32'h80, 1, 32'h80,
                     1, 32'h80, 1, 32'h104));
    // not taken: 10 -> 01
    tbl.push_back(mk(0, 32'h100, 1, 32'h100, 0, 32'h80, 1, 32'h80,
                     1, 32'h80, 1, 32'h104));
    // weak-NT now predicts fall-through
    tbl.push_back(mk(0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 32'h104, 0, 0));
    // retrain to 10
    tbl.push_back(mk(0, 32'h100, 1, 32'h100, 1, 32'h80, 0, 0,
                     0, 32'h104, 1, 32'h80));
    // correct direction, wrong target
    tbl.push_back(mk(0, 32'h100, 1, 32'h100, 1, 32'h90, 1, 32'h80,
                     1, 32'h80, 1, 32'h90));
    // target overwritten
    tbl.push_back(mk(0, 32'h100, 0, 0, 0, 0, 0, 0, 1, 32'h90, 0, 0));
    // alias 0x200 evicts 0x100
    tbl.push_back(mk(0, 32'h100, 1, 32'h200, 1, 32'h40, 0, 0,
                     1, 32'h90, 1, 32'h40));
    tbl.push_back(mk(0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 32'h104, 0, 0));
    tbl.push_back(mk(0, 32'h200, 0, 0, 0, 0, 0, 0, 1, 32'h40, 0, 0));
    // not-taken miss at 0x300: correctly predicted, no allocation
    tbl.push_back(mk(0, 32'h300, 1, 32'h300, 0, 32'h500, 0, 0,
                     0, 32'h304, 0, 32'h304));
    tbl.push_back(mk(0, 32'h300, 0, 0, 0, 0, 0, 0, 0, 32'h304, 0, 0));
    tbl.push_back(mk(0, 32'h200, 0, 0, 0, 0, 0, 0, 1, 32'h40, 0, 0));
    // other index untouched; pc[1:0] ignored
    tbl.push_back(mk(0, 32'h107, 0, 0, 0, 0, 0, 0, 0, 32'h10b, 0, 0));
    tbl.push_back(mk(0, 32'h202, 0, 0, 0, 0, 0, 0, 1, 32'h40, 0, 0));
    // wrap of pc+4, predicted-taken but not taken
    tbl.push_back(mk(0, 32'hffff_fffc, 1, 32'hffff_fffc, 0, 32'h10,
                     1, 32'h10, 0, 32'h0, 1, 32'h0));
    // update_valid low masks mispredict outputs and training
    tbl.push_back(mk(0, 32'h200, 0, 32'h200, 0, 32'h44, 1, 32'h40,
                     1, 32'h40, 0, 0));
    tbl.push_back(mk(0, 32'h200, 0, 0, 0, 0, 0, 0, 1, 32'h40, 0, 0));

    for (int i = 0; i < tbl.size(); i++)
      apply($sformatf("row%0d", i), tbl[i]);

    // reset wins over a simultaneous update; mispredict still follows inputs
    apply("rst_upd", mk(1, 32'h200, 1, 32'h400, 1, 32'h700, 0, 0,
                        1, 32'h40, 1, 32'h700));
    apply("rst_lk4", mk(0, 32'h400, 0, 0, 0, 0, 0, 0,
                        0, 32'h404, 0, 0));
    apply("rst_lk2", mk(0, 32'h200, 0, 0, 0, 0, 0, 0,
                        0, 32'h204, 0, 0));

    // saturate low: 10 -> 01 -> 00 -> 00, then 01 (NT), then 10 (T)
    apply("sat_a", mk(0, 32'h108, 1, 32'h108, 1, 32'h20, 0, 0,
                      0, 32'h10c, 1, 32'h20));
    apply("sat_b", mk(0, 32'h108, 1, 32'h108, 0, 32'h20, 1, 32'h20,
                      1, 32'h20, 1, 32'h10c));
    apply("sat_c", mk(0, 32'h108, 1, 32'h108, 0, 32'h20, 0, 0,
                      0, 32'h10c, 0, 32'h10c));
    apply("sat_d", mk(0, 32'h108, 1, 32'h108, 0, 32'h20, 0, 0,
                      0, 32'h10c, 0, 32'h10c));
    apply("sat_e", mk(0, 32'h108, 1, 32'h108, 1, 32'h20, 0, 0,
                      0, 32'h10c, 1, 32'h20));
    apply("sat_f", mk(0, 32'h108, 1, 32'h108, 1, 32'h20, 0, 0,
                      0, 32'h10c, 1, 32'h20));
    apply("sat_g", mk(0, 32'h108, 0, 0, 0, 0, 0, 0,
                      1, 32'h20, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
